ms_timer_sched: RTL and testbench

- Shares one millisecond countdown timer among NREQ requesters, such as dice roll animation, debounce windows and display hold times.
- Contains its own prescaler on CLK50M (nominally 50 000 cycles per 1 ms tick).
- Grants the timer round-robin, runs the requested duration in ms ticks, then pulses DONE to the owner.
- Sits between the top-level control FSMs and the clock domain root; it replaces per-client divider copies.

---
 rtl/ms_timer_sched_pkg.sv | 19 +
 rtl/ms_timer_sched_if.sv | 14 +
 rtl/ms_timer_sched_prescaler.sv | 21 ++
 rtl/ms_timer_sched.sv | 122 ++++++++++++
 tb/tb_ms_timer_sched.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ms_timer_sched_pkg.sv
// ms_timer_sched_pkg: shared definitions for the millisecond timer scheduler.
//   state_t          scheduler states IDLE/RUN/FIN
//   TICK_DIV_50M_1MS CLK50M cycles per 1 ms tick
//   rr_pick          one-hot round-robin pick from up to 8 requests, searching upward from ptr with wrap
package ms_timer_sched_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
    localparam int TICK_DIV_50M_1MS = 50000;
    // Walks the offsets from the far end back to ptr so the last hit is the nearest one.
    function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [7:0] g;
        logic [2:0] j;
        g = '0;
        for (int i = n - 1; i >= 0; i--) begin
            j = 3'((int'(ptr) + i) % n);
            if (req[j]) g = 8'(1) << j;
        end
        return g;
    endfunction
endpackage

// File: rtl/ms_timer_sched_if.sv
// ms_timer_sched_if: requester-side bus of the shared ms timer.
//   req  level request per client      dur  packed per-client durations in ms
//   gnt  one-hot current owner         done one-cycle completion pulse
//   busy a grant is active
//   master: client side, slave: scheduler side
interface ms_timer_sched_if #(parameter int NREQ = 4, parameter int DUR_W = 10);
    logic [NREQ-1:0]       req;
    logic [NREQ*DUR_W-1:0] dur;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    modport master(output req, dur, input gnt, done, busy);
    modport slave(input req, dur, output gnt, done, busy);
endinterface

// File: rtl/ms_timer_sched_prescaler.sv
// ms_prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
//   CLK50M clock, RSTN async active-low reset
//   clr    synchronous clear to 0 (wins over en)
//   en     count enable
//   wrap   high during the enabled cycle in which the count is TICK_DIV-1
module ms_prescaler #(
    parameter int TICK_DIV = 50000,
    parameter int PW       = 16
) (
    input  logic CLK50M,
    input  logic RSTN,
    input  logic clr,
    input  logic en,
    output logic wrap
);
    logic [PW-1:0] cnt;
    assign wrap = en && cnt == PW'(TICK_DIV - 1);
    always_ff @(posedge CLK50M or negedge RSTN)
        if (!RSTN) cnt <= '0;
        else cnt <= clr || wrap ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/ms_timer_sched.sv
// ms_timer_sched: one millisecond countdown timer shared round-robin among NREQ requesters.
//   CLK50M   system clock
//   RSTN     async active-low reset; a run in progress is discarded without DONE
//   bus      slave side of ms_timer_sched_if (req, dur in; gnt, done, busy out)
//   TICK_1MS one-cycle pulse per ms tick while running; present only with
//            MS_TIMER_SCHED_TICK_OUT_EN defined
module ms_timer_sched
    import ms_timer_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DUR_W    = 10,
    parameter int TICK_DIV = TICK_DIV_50M_1MS,
    parameter int PW       = 16
) (
    input logic CLK50M,
    input logic RSTN,
    ms_timer_sched_if.slave bus
`ifdef MS_TIMER_SCHED_TICK_OUT_EN
    , output logic TICK_1MS
`endif
);
    state_t state, state_n;
    logic [NREQ-1:0] gnt, gnt_n, done, done_n, pick;
    logic busy, busy_n, tick;
    logic [2:0] idx, idx_n, ptr, ptr_n, pick_idx, ptr_nxt;
    logic [DUR_W-1:0] rem, rem_n, dur_sel;

    assign bus.gnt  = gnt;
    assign bus.done = done;
    assign bus.busy = busy;

    // Prescaler restarts from 0 on every grant because it is held clear outside RUN.
    ms_prescaler #(.TICK_DIV(TICK_DIV), .PW(PW)) u_pre (
        .CLK50M(CLK50M),
        .RSTN(RSTN),
        .clr(state != RUN),
        .en(state == RUN),
        .wrap(tick)
    );

    always_comb begin
        pick = NREQ'(rr_pick(8'(bus.req), ptr, NREQ));
        pick_idx = '0;
        dur_sel = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick[i]) begin
                pick_idx = 3'(i);
                dur_sel = bus.dur[i*DUR_W +: DUR_W];
            end
    end

    assign ptr_nxt = idx == 3'(NREQ - 1) ? '0 : idx + 3'd1;

    // Abort is checked before completion so a dropped request never sees DONE.
    always_comb begin
        state_n = state;
        gnt_n = gnt;
        done_n = '0;
        busy_n = busy;
        rem_n = rem;
        idx_n = idx;
        ptr_n = ptr;
        case (state)
            IDLE:
                if (|bus.req) begin
                    state_n = RUN;
                    gnt_n = pick;
                    idx_n = pick_idx;
                    rem_n = dur_sel;
                    busy_n = 1'b1;
                end
            RUN:
                if (~|(bus.req & gnt)) begin
                    state_n = IDLE;
                    gnt_n = '0;
                    busy_n = 1'b0;
                    ptr_n = ptr_nxt;
                end else if (rem == '0 || (tick && rem == DUR_W'(1))) begin
                    state_n = FIN;
                    gnt_n = '0;
                    done_n = gnt;
                end else if (tick) rem_n = rem - 1'b1;
            FIN: begin
                state_n = IDLE;
                busy_n = 1'b0;
                ptr_n = ptr_nxt;
            end
            default: begin
                state_n = IDLE;
                gnt_n = '0;
                busy_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK50M or negedge RSTN)
        if (!RSTN) begin
            state <= IDLE;
            gnt <= '0;
            done <= '0;
            busy <= 1'b0;
            rem <= '0;
            idx <= '0;
            ptr <= '0;
        end else begin
            state <= state_n;
            gnt <= gnt_n;
            done <= done_n;
            busy <= busy_n;
            rem <= rem_n;
            idx <= idx_n;
            ptr <= ptr_n;
        end

`ifdef MS_TIMER_SCHED_TICK_OUT_EN
    logic tick_q;
    assign TICK_1MS = tick_q;
    always_ff @(posedge CLK50M or negedge RSTN)
        if (!RSTN) tick_q <= 1'b0;
        else tick_q <= tick;
`endif
endmodule

// File: tb/tb_ms_timer_sched.sv
// tb_ms_timer_sched: directed scenarios plus random traffic, checked against a deadline-based reference model.
module tb_ms_timer_sched;
    localparam int N = 4, DW = 10, TD = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_FIN = 2;
    typedef struct {int c; int t;} ev_t;

    logic CLK50M = 1'b0;
    logic RSTN = 1'b0;
    ms_timer_sched_if #(.NREQ(N), .DUR_W(DW)) bus();
`ifdef MS_TIMER_SCHED_TICK_OUT_EN
    logic tick_1ms;
`endif

    ms_timer_sched #(.NREQ(N), .DUR_W(DW), .TICK_DIV(TD), .PW(16)) dut (
        .CLK50M(CLK50M),
        .RSTN(RSTN),
        .bus(bus)
`ifdef MS_TIMER_SCHED_TICK_OUT_EN
        , .TICK_1MS(tick_1ms)
`endif
    );

    always #10 CLK50M = ~CLK50M;

    int checks = 0, failures = 0, cyc = 0;
    int m_mode = M_IDLE, m_owner = 0, m_ptr = 0, m_start = 0, m_end = 0;
    bit m_tick = 1'b0;
    ev_t exp_gnt[$];
    ev_t exp_done[$];
    logic [N-1:0] prev_gnt = '0;

    function automatic void chk(string nm, int act, int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp_v, cyc);
        end
    endfunction

    function automatic void flag(string nm, int act);
        checks++;
        failures++;
        $display("FAIL %s: got %0d with nothing expected at cycle %0d", nm, act, cyc);
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_ptr = 0;
        m_tick = 1'b0;
        exp_gnt.delete();
        exp_done.delete();
    endtask

    // Grant at edge k completes at k+D*TD (k+1 for D=0); ticks fall every TD edges after the grant.
    task automatic model_step();
        int d;
        cyc++;
        if (!RSTN) begin
            model_reset();
            return;
        end
        m_tick = 1'b0;
        if (m_mode == M_IDLE) begin
            for (int j = 0; j < N; j++)
                if (m_mode == M_IDLE && bus.req[(m_ptr + j) % N]) begin
                    m_owner = (m_ptr + j) % N;
                    d = int'(bus.dur[m_owner*DW +: DW]);
                    m_start = cyc;
                    m_end = cyc + (d == 0 ? 1 : d * TD);
                    m_mode = M_RUN;
                    exp_gnt.push_back('{m_owner, cyc});
                end
        end else if (m_mode == M_RUN) begin
            m_tick = ((cyc - m_start) % TD) == 0;
            if (!bus.req[m_owner]) begin
                m_mode = M_IDLE;
                m_ptr = (m_owner + 1) % N;
            end else if (cyc == m_end) begin
                m_mode = M_FIN;
                exp_done.push_back('{m_owner, cyc});
            end
        end else begin
            m_mode = M_IDLE;
            m_ptr = (m_owner + 1) % N;
        end
    endtask

    initial forever begin
        @(posedge CLK50M);
        model_step();
    end

    initial begin : mon
        ev_t e;
        forever begin
            @(negedge CLK50M);
            if (RSTN) begin
                chk("gnt_level", int'(bus.gnt), m_mode == M_RUN ? 1 << m_owner : 0);
                chk("busy", int'(bus.busy), int'(m_mode != M_IDLE));
`ifdef MS_TIMER_SCHED_TICK_OUT_EN
                chk("tick_1ms", int'(tick_1ms), int'(m_tick));
`endif
                if (bus.gnt != '0 && prev_gnt == '0) begin
                    if (exp_gnt.size() == 0) flag("gnt_unexpected", int'(bus.gnt));
                    else begin
                        e = exp_gnt.pop_front();
                        chk("gnt_client", onehot_idx(bus.gnt), e.c);
                        chk("gnt_cycle", cyc, e.t);
                    end
                end
                if (bus.done != '0) begin
                    if (exp_done.size() == 0) flag("done_unexpected", int'(bus.done));
                    else begin
                        e = exp_done.pop_front();
                        chk("done_onehot", $countones(bus.done), 1);
                        chk("done_client", onehot_idx(bus.done), e.c);
                        chk("done_cycle", cyc, e.t);
                    end
                end
            end
            prev_gnt = bus.gnt;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK50M);
    endtask

    task automatic set_dur(input int i, input int v);
        bus.dur[i*DW +: DW] = DW'(v);
    endtask

    task automatic wait_gnt(input logic [N-1:0] m, input int bound);
        int n = 0;
        while (!(|(bus.gnt & m)) && n < bound) begin
            @(negedge CLK50M);
            n++;
        end
        chk("gnt_wait_expired", int'(n >= bound), 0);
    endtask

    task automatic hold_until_done(input logic [N-1:0] m, input int bound);
        int n = 0;
        while (!(|(bus.done & m)) && n < bound) begin
            @(negedge CLK50M);
            n++;
        end
        chk("done_wait_expired", int'(n >= bound), 0);
    endtask

    initial begin
        bus.req = '0;
        bus.dur = '0;
        wait_cycles(3);
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_busy", int'(bus.busy), 0);
        RSTN = 1'b1;
        wait_cycles(1);
        set_dur(0, 3);
        bus.req = 4'b0001;
        hold_until_done(4'b0001, 40);
        bus.req = '0;
        wait_cycles(3);
        set_dur(1, 0);
        bus.req = 4'b0010;
        hold_until_done(4'b0010, 10);
        bus.req = '0;
        wait_cycles(3);
        for (int i = 0; i < N; i++) set_dur(i, 1);
        bus.req = 4'b1111;
        wait_cycles(30);
        bus.req = '0;
        wait_cycles(3);
        set_dur(2, 5);
        bus.req = 4'b0100;
        wait_gnt(4'b0100, 10);
        wait_cycles(7);
        bus.req = '0;
        wait_cycles(1);
        set_dur(0, 1);
        set_dur(3, 1);
        bus.req = 4'b1001;
        hold_until_done(4'b1001, 20);
        bus.req = '0;
        wait_cycles(3);
        set_dur(0, 2);
        bus.req = 4'b0001;
        wait_gnt(4'b0001, 10);
        wait_cycles(7);
        bus.req = '0;
        wait_cycles(5);
        set_dur(0, 4);
        bus.req = 4'b0001;
        wait_gnt(4'b0001, 10);
        wait_cycles(8);
        #1 RSTN = 1'b0;
        model_reset();
        #1;
        chk("async_rst_gnt", int'(bus.gnt), 0);
        chk("async_rst_done", int'(bus.done), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        wait_cycles(2);
        RSTN = 1'b1;
        hold_until_done(4'b0001, 40);
        bus.req = '0;
        wait_cycles(3);
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK50M);
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && bus.done[i]) bus.req[i] = 1'b0;
                else if (bus.req[i] && $urandom_range(0, 39) == 0) bus.req[i] = 1'b0;
                else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    set_dur(i, int'($urandom_range(0, 5)));
                    bus.req[i] = 1'b1;
                end else if ($urandom_range(0, 7) == 0) set_dur(i, int'($urandom_range(0, 5)));
            end
        end
        bus.req = '0;
        wait_cycles(4);
        chk("gnt_queue_left", exp_gnt.size(), 0);
        chk("done_queue_left", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
